// File: rtl/pkt_rx_parser.sv
// Receive-side packet parser: validates LEN/CSUM framed packets and buffers payload
// in a commit/rollback FIFO; saturating good/bad/drop counters via a CPU port.
module pkt_rx_parser #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rxd,
  input  logic       rx_vld,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_vld,
  input  logic       out_rdy,
  input  logic       cpu_sel,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, DISCARD} state_t;
  state_t state_r, state_s;

  logic [8:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, cwr_ptr_r, rd_ptr_r;
  logic [7:0]    remain_r, sum_r;
  logic [7:0]    good_cnt_r, bad_cnt_r, drop_cnt_r;
  logic          enable_r;

  logic          load_len_s, push_s, pop_s, commit_s, rollback_s;
  logic          good_inc_s, bad_inc_s, drop_inc_s;
  logic [PW:0]   free_s;
  logic [8:0]    head_s;
  logic [7:0]    rd_data_s;
  logic          cpu_wr_s, clr_s, unused_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    else return v;
  endfunction

  assign free_s   = (PW+1)'(DEPTH) - {1'b0, wr_ptr_r - rd_ptr_r};
  assign out_vld  = (rd_ptr_r != cwr_ptr_r);
  assign pop_s    = out_vld & out_rdy;
  assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign out_data = out_vld ? head_s[7:0] : 8'd0;
  assign out_last = out_vld & head_s[8];
  assign cpu_wr_s = cpu_sel & cpu_rw;
  assign clr_s    = cpu_wr_s & (cpu_addr == 8'h00) & cpu_din[1];
  assign unused_s = ^cpu_din[7:2];

  // Next-state and per-cycle control decode for the receive FSM.
  always_comb begin
    state_s    = state_r;
    load_len_s = 1'b0;
    push_s     = 1'b0;
    commit_s   = 1'b0;
    rollback_s = 1'b0;
    good_inc_s = 1'b0;
    bad_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_vld && enable_r) begin
          load_len_s = 1'b1;
          if ((rxd == 8'd0) || (rxd > 8'(MAX_LEN))) begin
            bad_inc_s = 1'b1;
            state_s   = DISCARD;
          end else if ({24'd0, rxd} > 32'(free_s)) begin
            drop_inc_s = 1'b1;
            state_s    = DISCARD;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (!rx_vld) begin
          rollback_s = 1'b1;
          bad_inc_s  = 1'b1;
          state_s    = IDLE;
        end else begin
          push_s  = 1'b1;
          state_s = (remain_r == 8'd1) ? CSUM : PAYLOAD;
        end
      end
      CSUM: begin
        if (!rx_vld) begin
          rollback_s = 1'b1;
          bad_inc_s  = 1'b1;
          state_s    = IDLE;
        end else if (rxd == sum_r) begin
          commit_s   = 1'b1;
          good_inc_s = 1'b1;
          state_s    = DISCARD;
        end else begin
          rollback_s = 1'b1;
          bad_inc_s  = 1'b1;
          state_s    = DISCARD;
        end
      end
      DISCARD: begin
        state_s = rx_vld ? DISCARD : IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state, byte countdown, running checksum and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      remain_r  <= 8'd0;
      sum_r     <= 8'd0;
      wr_ptr_r  <= '0;
      cwr_ptr_r <= '0;
      rd_ptr_r  <= '0;
    end else begin
      state_r <= state_s;
      if (load_len_s) begin
        remain_r <= rxd;
        sum_r    <= rxd;
      end else if (push_s) begin
        remain_r <= remain_r - 8'd1;
        sum_r    <= sum_r + rxd;
      end
      // Writes go to the speculative pointer; only a good checksum publishes them.
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      else if (rollback_s) wr_ptr_r <= cwr_ptr_r;
      if (commit_s) cwr_ptr_r <= wr_ptr_r;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Payload storage; the tag bit marks the final byte of each packet.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= {remain_r == 8'd1, rxd};
  end

  // CPU register read mux.
  always_comb begin
    rd_data_s = 8'h00;
    case (cpu_addr)
      8'h00:   rd_data_s = {7'd0, enable_r};
      8'h01:   rd_data_s = good_cnt_r;
      8'h02:   rd_data_s = bad_cnt_r;
      8'h03:   rd_data_s = drop_cnt_r;
      8'h04:   rd_data_s = {6'd0, state_r != IDLE, rd_ptr_r == cwr_ptr_r};
      default: rd_data_s = 8'h00;
    endcase
  end

  // Control register, counters (clear beats increment) and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_r   <= 1'b1;
      good_cnt_r <= 8'd0;
      bad_cnt_r  <= 8'd0;
      drop_cnt_r <= 8'd0;
      cpu_dout   <= 8'd0;
    end else begin
      if (cpu_wr_s && (cpu_addr == 8'h00)) enable_r <= cpu_din[0];
      if (clr_s) begin
        good_cnt_r <= 8'd0;
        bad_cnt_r  <= 8'd0;
        drop_cnt_r <= 8'd0;
      end else begin
        good_cnt_r <= sat_inc(good_cnt_r, good_inc_s);
        bad_cnt_r  <= sat_inc(bad_cnt_r, bad_inc_s);
        drop_cnt_r <= sat_inc(drop_cnt_r, drop_inc_s);
      end
      if (cpu_sel && !cpu_rw) cpu_dout <= rd_data_s;
    end
  end
endmodule

// File: tb/tb_pkt_rx_parser.sv
// Bench for pkt_rx_parser: packet-level reference model, per-cycle compare, directed
// literal checks and a randomized packet mix.
module tb_pkt_rx_parser;
  localparam int DEPTH = 64, MAX_LEN = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rxd = 8'd0, cpu_addr = 8'd0, cpu_din = 8'd0;
  logic rx_vld = 1'b0, out_rdy = 1'b0, cpu_sel = 1'b0, cpu_rw = 1'b0;
  logic [7:0] out_data, cpu_dout;
  logic out_last, out_vld;

  always #5 clk = ~clk;

  pkt_rx_parser #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_vld(rx_vld),
    .out_data(out_data), .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy),
    .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout));

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: committed-byte queue plus the bytes of the run in progress.
  logic [8:0] exp_q[$];
  logic [7:0] pkt_q[$];
  bit in_run = 0, run_active = 0, decided = 0, m_enable = 1;
  int run_len = 0;
  logic [7:0] m_good = 0, m_bad = 0, m_drop = 0, exp_dout = 0;

  function automatic logic [7:0] sat(input logic [7:0] v, input bit inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  task automatic model_step();
    int occ, s;
    bit clr, busy, gi, bi, di;
    gi = 0; bi = 0; di = 0;
    occ  = exp_q.size();
    busy = in_run && run_active;
    clr  = cpu_sel && cpu_rw && cpu_addr == 8'h00 && cpu_din[1];
    if (cpu_sel && !cpu_rw) begin
      case (cpu_addr)
        8'h00:   exp_dout = {7'd0, m_enable};
        8'h01:   exp_dout = m_good;
        8'h02:   exp_dout = m_bad;
        8'h03:   exp_dout = m_drop;
        8'h04:   exp_dout = {6'd0, busy, occ == 0};
        default: exp_dout = 8'h00;
      endcase
    end
    if (occ > 0 && out_rdy) void'(exp_q.pop_front());
    if (rx_vld) begin
      if (!in_run) begin
        in_run = 1; run_active = m_enable; decided = 0; run_len = int'(rxd); pkt_q.delete();
        if (run_active) begin
          if (run_len == 0 || run_len > MAX_LEN) begin bi = 1; decided = 1; end
          else if (run_len > DEPTH - occ) begin di = 1; decided = 1; end
        end
      end else if (run_active && !decided) begin
        if (pkt_q.size() < run_len) pkt_q.push_back(rxd);
        else begin
          s = run_len;
          foreach (pkt_q[i]) s += int'(pkt_q[i]);
          if (rxd == s[7:0]) begin
            gi = 1;
            foreach (pkt_q[i]) exp_q.push_back({i == run_len - 1, pkt_q[i]});
          end else bi = 1;
          decided = 1;
        end
      end
    end else if (in_run) begin
      in_run = 0;
      if (run_active && !decided) bi = 1;
    end
    if (clr) begin m_good = 0; m_bad = 0; m_drop = 0; end
    else begin m_good = sat(m_good, gi); m_bad = sat(m_bad, bi); m_drop = sat(m_drop, di); end
    if (cpu_sel && cpu_rw && cpu_addr == 8'h00) m_enable = cpu_din[0];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete(); in_run = 0; m_good = 0; m_bad = 0; m_drop = 0;
        m_enable = 1; exp_dout = 0;
      end else model_step();
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_vld", out_vld, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("out_data", out_data, exp_q[0][7:0]);
          chk("out_last", out_last, exp_q[0][8]);
        end
        chk("cpu_dout", cpu_dout, exp_dout);
      end
    end
  end

  // Log of accepted output bytes for directed checks.
  logic [8:0] got_q[$];
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && out_vld && out_rdy) got_q.push_back({out_last, out_data});
    end
  end

  bit rand_rdy = 0;
  int rdy_pct = 50;
  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_rdy = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) begin @(negedge clk); rx_vld = 1'b1; rxd = b[i]; end
    @(negedge clk); rx_vld = 1'b0; rxd = 8'd0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk); cpu_sel = 1'b0; cpu_rw = 1'b0;
  endtask

  task automatic cpu_rd_raw(input logic [7:0] a);
    @(negedge clk); cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = a;
    @(negedge clk); cpu_sel = 1'b0;
  endtask

  task automatic cpu_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    cpu_rd_raw(a);
    chk(name, cpu_dout, exp);
  endtask

  task automatic mk_pkt(input int len, input bit good, output logic [7:0] p[$]);
    int s;
    logic [7:0] b;
    p.delete(); p.push_back(len[7:0]); s = len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom); p.push_back(b); s += int'(b);
    end
    p.push_back(good ? s[7:0] : (s[7:0] ^ 8'h5A));
  endtask

  initial begin
    logic [7:0] p[$];
    int lasts;
    repeat (3) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    rst_n = 1'b1;

    @(negedge clk); cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h00;
    chk("dout_latency", cpu_dout, 0);
    @(negedge clk); cpu_sel = 1'b0;
    chk("ctrl_reset", cpu_dout, 8'h01);

    out_rdy = 1'b1; got_q.delete();
    send('{8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    chk("good_first_vld", out_vld, 1);
    chk("good_first_data", out_data, 8'h11);
    repeat (4) @(negedge clk);
    chk("good_nbytes", got_q.size(), 3);
    chk("good_b0", got_q[0], 9'h011);
    chk("good_b1", got_q[1], 9'h022);
    chk("good_b2", got_q[2], 9'h133);
    cpu_rd("good_cnt", 8'h01, 8'h01);

    cpu_wr(8'h00, 8'h03); got_q.delete();
    send('{8'h02, 8'hAA, 8'hBB, 8'h00});
    repeat (2) @(negedge clk);
    chk("badcs_no_out", got_q.size(), 0);
    cpu_rd("badcs_cnt", 8'h02, 8'h01);
    cpu_rd("badcs_status", 8'h04, 8'h01);
    send('{8'h01, 8'h05, 8'h06});
    repeat (3) @(negedge clk);
    chk("after_bad_n", got_q.size(), 1);
    chk("after_bad_b0", got_q[0], 9'h105);

    cpu_wr(8'h00, 8'h03); got_q.delete();
    send('{8'h00, 8'h55, 8'h66});
    send('{8'h21, 8'h01, 8'h02, 8'h03});
    cpu_rd("len_bad_cnt", 8'h02, 8'h02);
    cpu_rd("len_good_cnt", 8'h01, 8'h00);
    chk("len_no_out", got_q.size(), 0);

    cpu_wr(8'h00, 8'h03);
    send('{8'h04, 8'h01, 8'h02});
    cpu_rd("trunc_bad_cnt", 8'h02, 8'h01);
    send('{8'h02, 8'h10, 8'h20, 8'h32});
    repeat (3) @(negedge clk);
    chk("trunc_next_n", got_q.size(), 2);
    chk("trunc_next_b1", got_q[1], 9'h120);

    cpu_wr(8'h00, 8'h03); out_rdy = 1'b0;
    mk_pkt(32, 1, p); send(p);
    mk_pkt(32, 1, p); send(p);
    send('{8'h01, 8'h07, 8'h07});
    cpu_rd("full_drop_cnt", 8'h03, 8'h01);
    cpu_rd("full_good_cnt", 8'h01, 8'h02);
    cpu_rd("full_status", 8'h04, 8'h00);
    got_q.delete(); out_rdy = 1'b1;
    repeat (80) @(negedge clk);
    chk("full_nbytes", got_q.size(), 64);
    lasts = 0;
    foreach (got_q[i]) lasts += int'(got_q[i][8]);
    chk("full_nlast", lasts, 2);
    chk("full_last32", got_q[31][8], 1);
    chk("full_last64", got_q[63][8], 1);

    cpu_wr(8'h00, 8'h03);
    for (int i = 0; i < 256; i++) send('{8'h00});
    cpu_rd("bad_sat", 8'h02, 8'hFF);
    cpu_wr(8'h00, 8'h02);
    cpu_rd("clr_good", 8'h01, 8'h00);
    cpu_rd("clr_bad", 8'h02, 8'h00);
    cpu_rd("clr_drop", 8'h03, 8'h00);
    cpu_rd("clr_ctrl", 8'h00, 8'h00);
    send('{8'h01, 8'h09, 8'h0A});
    cpu_rd("dis_good", 8'h01, 8'h00);
    cpu_rd("unmapped", 8'h07, 8'h00);
    cpu_wr(8'h00, 8'h01);

    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      int kind, len, k;
      if (n % 50 == 0) rdy_pct = $urandom_range(5, 100);
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, MAX_LEN);
      case (kind)
        0: mk_pkt(len, 1, p);
        1: mk_pkt(len, 0, p);
        2: begin
          p.delete();
          p.push_back(($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
          repeat ($urandom_range(0, 4)) p.push_back(8'($urandom));
        end
        3: begin
          mk_pkt(len, 1, p);
          k = $urandom_range(1, len + 1);
          while (p.size() > k) void'(p.pop_back());
        end
        default: begin
          mk_pkt(len, 1, p);
          repeat ($urandom_range(1, 3)) p.push_back(8'($urandom));
        end
      endcase
      if (n == 150) begin
        fork
          send(p);
          begin
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            chk("rst_flush", out_vld, 0);
          end
        join
      end else if ($urandom_range(0, 3) == 0) begin
        fork
          send(p);
          begin
            repeat ($urandom_range(0, p.size())) @(negedge clk);
            if ($urandom_range(0, 1) != 0) cpu_wr(8'h00, 8'h03);
            else cpu_rd_raw(8'($urandom_range(0, 7)));
          end
        join
      end else send(p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    rand_rdy = 0;
    @(negedge clk); out_rdy = 1'b1;
    for (int i = 0; i < 200 && out_vld; i++) @(negedge clk);
    chk("drain", out_vld, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
